// File: rtl/dot_accumulator_if.sv
// Handshake bundle between the multiply-add stage, the dot-product accumulator
// and the result consumer. The master side produces partial sums and accepts
// results. The slave side is the accumulator.
interface dot_accumulator_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    // Partial-sum input channel
    logic             in_valid;
    logic             in_ready;
    logic [11:0]      in_data;
    logic             in_last;

    // Result output channel
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_count,
        input  out_overflow
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_count,
        output out_overflow
    );
endinterface

// File: rtl/dot_accumulator.sv
// Dot-product accumulator: sums signed 12-bit partial dot products into an
// ACC_W-bit accumulator until a beat flagged last. It then publishes the total,
// the beat count and a sticky overflow flag through a one-deep result register.
module dot_accumulator #(
    parameter int ACC_W    = 24,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    dot_accumulator_if.slave   bus
);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Running accumulation for the vector in progress
    logic signed [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    ovf_reg;

    // Values the accumulation would take if the current beat is accepted
    logic signed [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0]        cnt_next;
    logic                    ovf_next;

    // Result register
    logic                    out_valid_reg;
    logic [ACC_W-1:0]        out_data_reg;
    logic [CNT_W-1:0]        out_count_reg;
    logic                    out_ovf_reg;

    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] sum_wrap;
    logic                    beat_ovf;
    logic                    in_ready_int;
    logic                    beat_fire;
    logic                    last_fire;
    logic                    out_fire;

    // A beat may only enter when the result register is free, or is being
    // drained this cycle. The result register then always has room for the
    // result of a last beat.
    assign in_ready_int = !flush && (!out_valid_reg || bus.out_ready);
    assign beat_fire    = bus.in_valid && in_ready_int;
    assign last_fire    = beat_fire && bus.in_last;
    assign out_fire     = out_valid_reg && bus.out_ready;

    assign bus.in_ready     = in_ready_int;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_data     = out_data_reg;
    assign bus.out_count    = out_count_reg;
    assign bus.out_overflow = out_ovf_reg;

    // Sign-extend the partial sum and form the raw wrapped sum
    assign in_ext   = ACC_W'($signed(bus.in_data));
    assign sum_wrap = acc_reg + in_ext;

    // Signed overflow: operands agree in sign, result does not
    assign beat_ovf = (acc_reg[ACC_W-1] == in_ext[ACC_W-1]) &&
                      (sum_wrap[ACC_W-1] != acc_reg[ACC_W-1]);

    generate
        if (SATURATE != 0) begin : g_sat
            // Clamp toward the sign of the operands when the sum overflows
            always_comb begin
                acc_next = sum_wrap;
                if (beat_ovf) begin
                    acc_next = acc_reg[ACC_W-1] ? ACC_MIN : ACC_MAX;
                end
            end
        end else begin : g_wrap
            assign acc_next = sum_wrap;
        end
    endgenerate

    // Beat counter sticks at all-ones so long vectors report "at least max"
    assign cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign ovf_next = ovf_reg | beat_ovf;

    // Accumulator state: cleared by flush or at the end of each vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (flush || last_fire) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (beat_fire) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
        end
    end

    // Result register: a last beat loads it even while the old result drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_count_reg <= '0;
            out_ovf_reg   <= 1'b0;
        end else if (last_fire) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= acc_next;
            out_count_reg <= cnt_next;
            out_ovf_reg   <= ovf_next;
        end else if (out_fire) begin
            out_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dot_accumulator.sv
// Testbench for dot_accumulator. Three configurations run in lockstep from one
// stimulus stream: 24-bit wrap, 12-bit wrap and 12-bit saturate. Each one is
// compared every cycle against an integer-arithmetic reference model.
module tb_dot_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] in_data = 12'd0;

    always #5 clk = ~clk;

    dot_accumulator_if #(.ACC_W(24), .CNT_W(8)) if24 ();
    dot_accumulator_if #(.ACC_W(12), .CNT_W(8)) ifw ();
    dot_accumulator_if #(.ACC_W(12), .CNT_W(8)) ifs ();

    assign if24.in_valid = in_valid;  assign if24.in_data = in_data;
    assign if24.in_last  = in_last;   assign if24.out_ready = out_ready;
    assign ifw.in_valid  = in_valid;  assign ifw.in_data  = in_data;
    assign ifw.in_last   = in_last;   assign ifw.out_ready  = out_ready;
    assign ifs.in_valid  = in_valid;  assign ifs.in_data  = in_data;
    assign ifs.in_last   = in_last;   assign ifs.out_ready  = out_ready;

    dot_accumulator #(.ACC_W(24), .CNT_W(8), .SATURATE(0)) u_dut24 (
        .clk(clk), .rst(rst), .flush(flush), .bus(if24.slave));
    dot_accumulator #(.ACC_W(12), .CNT_W(8), .SATURATE(0)) u_dutw (
        .clk(clk), .rst(rst), .flush(flush), .bus(ifw.slave));
    dot_accumulator #(.ACC_W(12), .CNT_W(8), .SATURATE(1)) u_duts (
        .clk(clk), .rst(rst), .flush(flush), .bus(ifs.slave));

    // Observed outputs, indexed by configuration
    logic [2:0]  got_valid, got_ready, got_ovf;
    logic [31:0] got_data [3];
    logic [7:0]  got_cnt  [3];
    assign got_valid = {ifs.out_valid, ifw.out_valid, if24.out_valid};
    assign got_ready = {ifs.in_ready, ifw.in_ready, if24.in_ready};
    assign got_ovf   = {ifs.out_overflow, ifw.out_overflow, if24.out_overflow};
    assign got_data[0] = 32'(if24.out_data);
    assign got_data[1] = 32'(ifw.out_data);
    assign got_data[2] = 32'(ifs.out_data);
    assign got_cnt[0]  = if24.out_count;
    assign got_cnt[1]  = ifw.out_count;
    assign got_cnt[2]  = ifs.out_count;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int     width  [3] = '{24, 12, 12};
    bit     sat    [3] = '{1'b0, 1'b0, 1'b1};
    longint acc_m  [3];
    int     cnt_m  [3];
    bit     ovf_m  [3];
    bit     pend_v [3];
    longint pend_d [3];
    int     pend_c [3];
    bit     pend_o [3];
    bit     exp_ready;

    function automatic longint mask_of(input int w);
        return (longint'(1) <<< w) - 1;
    endfunction

    // Add one beat with true integer arithmetic, then fold back into range
    task automatic model_beat(input int c, input longint x);
        longint s;
        longint maxv;
        longint minv;
        s    = acc_m[c] + x;
        maxv = (longint'(1) <<< (width[c] - 1)) - 1;
        minv = -(longint'(1) <<< (width[c] - 1));
        if (s > maxv || s < minv) begin
            ovf_m[c] = 1'b1;
            if (sat[c]) begin
                s = (s > maxv) ? maxv : minv;
            end else begin
                s = s & mask_of(width[c]);
                if (s > maxv) s = s - (longint'(1) <<< width[c]);
            end
        end
        acc_m[c] = s;
        cnt_m[c] = (cnt_m[c] < 255) ? cnt_m[c] + 1 : 255;
    endtask

    // Cycle monitor: compare against the model, then advance the model to the next edge
    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                acc_m[c] = 0; cnt_m[c] = 0; ovf_m[c] = 0; pend_v[c] = 0;
            end
        end else begin
            exp_ready = !flush && (!pend_v[0] || out_ready);
            for (int c = 0; c < 3; c++) begin
                check($sformatf("in_ready[%0d]", c), got_ready[c], exp_ready);
                check($sformatf("out_valid[%0d]", c), got_valid[c], pend_v[c]);
                if (pend_v[c]) begin
                    check($sformatf("out_data[%0d]", c), got_data[c], pend_d[c] & mask_of(width[c]));
                    check($sformatf("out_count[%0d]", c), got_cnt[c], pend_c[c]);
                    check($sformatf("out_overflow[%0d]", c), got_ovf[c], pend_o[c]);
                end
            end
            for (int c = 0; c < 3; c++) begin
                if (pend_v[c] && out_ready) begin
                    $display("%0t cfg=%0d result data=%0d count=%0d ovf=%0d",
                             $time, c, pend_d[c], pend_c[c], pend_o[c]);
                end
                if (flush) begin
                    acc_m[c] = 0; cnt_m[c] = 0; ovf_m[c] = 0;
                end
                if (in_valid && exp_ready) begin
                    model_beat(c, longint'($signed(in_data)));
                end
                if (in_valid && exp_ready && in_last) begin
                    pend_v[c] = 1; pend_d[c] = acc_m[c]; pend_c[c] = cnt_m[c]; pend_o[c] = ovf_m[c];
                    acc_m[c] = 0; cnt_m[c] = 0; ovf_m[c] = 0;
                end else if (pend_v[c] && out_ready) begin
                    pend_v[c] = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [11:0] d, input logic l);
        int  n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l;
        do begin
            @(negedge clk);
            ok = got_ready[0];
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 100);
        check("send_accept", ok, 1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_valid", got_valid, 0);
        check("rst_data", got_data[0], 0);
        check("rst_count", got_cnt[0], 0);
        check("rst_ovf", got_ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);

        // Three beats of 256
        send(12'd256, 0); send(12'd256, 0); send(12'd256, 1);
        check("sum3_valid", got_valid[0], 1);
        check("sum3_data", got_data[0], 768);
        check("sum3_count", got_cnt[0], 3);
        check("sum3_ovf", got_ovf[0], 0);
        idle(1);

        // Negative beats sign-extend
        send(12'hF20, 0); send(12'hF20, 1);
        check("neg_data", got_data[0], 32'hFFFE40);
        check("neg_count", got_cnt[0], 2);
        idle(1);

        // Overflow at 12 bits: wrap versus clamp
        for (int i = 0; i < 8; i++) send(12'd256, i == 7);
        check("wrap_data", got_data[1], 32'h800);
        check("wrap_ovf", got_ovf[1], 1);
        check("sat_data", got_data[2], 32'h7FF);
        check("sat_ovf", got_ovf[2], 1);
        check("wide_data", got_data[0], 2048);
        idle(1);

        // Back-pressure: pending result blocks the input and holds still
        out_ready = 1'b0;
        send(12'd1, 1);
        in_valid = 1'b1; in_data = 12'd9; in_last = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_ready", got_ready[0], 0);
            check("bp_valid", got_valid[0], 1);
            check("bp_data", got_data[0], 1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        idle(1);
        check("bp_drained", got_valid[0], 0);
        send(12'd10, 0); send(12'd20, 1);
        check("bp_next_data", got_data[0], 30);
        check("bp_next_count", got_cnt[0], 2);

        // Flush discards the partial vector and the offered beat
        send(12'd100, 0); send(12'd50, 0);
        flush = 1'b1; in_valid = 1'b1; in_data = 12'd7; in_last = 1'b0;
        #1 check("flush_ready", got_ready[0], 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        send(12'd5, 1);
        check("flush_data", got_data[0], 5);
        check("flush_count", got_cnt[0], 1);

        // Back-to-back single-beat vectors, then reset mid-stream
        for (int v = 1; v <= 3; v++) begin
            in_valid = 1'b1; in_data = 12'(v); in_last = 1'b1;
            @(posedge clk); #1;
            check("b2b_valid", got_valid[0], 1);
            check("b2b_data", got_data[0], v);
        end
        in_valid = 1'b0; in_last = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_rst_valid", got_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(12'd4, 1);
        check("post_rst_data", got_data[0], 4);
        check("post_rst_count", got_cnt[0], 1);
        idle(1);

        // Randomized traffic, checked every cycle by the monitor
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 12'($urandom);
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(2);

        // Count saturation on a long vector
        for (int i = 0; i < 300; i++) send(12'($urandom), i == 299);
        check("cnt_sat24", got_cnt[0], 255);
        check("cnt_sat12", got_cnt[2], 255);
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dot_accumulator.md
Name: dot_accumulator

Overview:
- Sits directly downstream of the 4-pair signed multiply-add stage.
- Consumes its 12-bit two's-complement partial dot products (four 4x4 signed products summed) one beat per cycle over a valid/ready handshake.
- Accumulates beats into a wider signed accumulator until a beat marked last, then presents the full dot product, beat count and overflow flag on a registered output handshake.

Parameters:
ACC_W, 24, accumulator and result width in bits; legal range 12..32.
CNT_W, 8, beat-counter width in bits.
SATURATE, 0, 1 = clamp on signed overflow; 0 = two's-complement wrap.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous discard of the in-progress accumulation
in_valid  input  1  partial-sum beat valid
in_ready  output  1  block can accept a beat
in_data  input  12  signed partial dot product from the multiply-add stage
in_last  input  1  final beat of the current vector
out_valid  output  1  result register holds a result
out_ready  input  1  consumer accepts the result
out_data  output  ACC_W  signed accumulated dot product
out_count  output  CNT_W  number of beats in the vector
out_overflow  output  1  signed overflow occurred in the vector

Behaviour:
- Reset (async, rst=1):
  - acc, cnt and ovf clear to 0; out_valid=0; out_data, out_count and out_overflow clear to 0.
  - Any partial accumulation is lost.
- Handshakes:
  - Input beat accepted when in_valid & in_ready.
  - in_ready = !flush & (!out_valid | out_ready).
  - in_ready is combinational from out_ready and flush only; it never depends on in_valid.
  - Output accepted when out_valid & out_ready.
  - out_data, out_count and out_overflow are stable while out_valid=1 and out_ready=0.
- Arithmetic per accepted beat:
  - sum = acc + sign_extend(in_data to ACC_W).
  - Overflow when both operands have the same sign and sum's sign differs.
  - SATURATE=0: acc <= sum.
  - SATURATE=1: on overflow, acc <= max positive (operands non-negative) or min negative (operands negative).
  - ovf <= ovf | overflow.
  - cnt <= cnt+1, saturating at all-ones (never wraps).
- Non-last accepted beat: update acc, cnt and ovf as above.
- Last accepted beat (in_last=1):
  - Next cycle: out_data = final acc including this beat, out_count = cnt including this beat, out_overflow = ovf including this beat, out_valid=1.
  - Same edge: acc, cnt and ovf clear to 0, ready for the next vector.
  - Latency is 1 cycle from last-beat acceptance to out_valid.
- Output drain:
  - out_valid=1 & out_ready=1 & no new last beat → out_valid <= 0.
  - Output drained and a new last beat accepted in the same cycle → out_valid stays 1 with the new result. This gives back-to-back single-beat vectors at full throughput.
- flush=1:
  - acc, cnt and ovf clear to 0; in_ready=0, so no beat is accepted that cycle.
  - The pending output register and out_valid are unaffected; output draining proceeds normally.
- Single-beat vector (first beat has in_last=1): result = sign-extended in_data, count=1.
- Back-pressure: out_valid=1 & out_ready=0 → in_ready=0; in-progress accumulation holds.
- Reset mid-vector or with a pending result: everything is lost and out_valid drops asynchronously.
- Count saturation: with 2^CNT_W-1 or more beats, out_count reads all-ones; the data is still fully accumulated.

Test Plan:
- Three beats 256, 256, 256 (last on third), out_ready=1 → one cycle after the third beat: out_valid=1, out_data=768, out_count=3, out_overflow=0.
- Two beats 12'hF20 (-224) each, last on second → out_data=-448 sign-extended (24'hFFFE40), out_count=2.
- ACC_W=12, SATURATE=0, eight beats of 256 → out_data=12'h800 (-2048), out_overflow=1. Same stimulus with SATURATE=1 → 12'h7FF, out_overflow=1.
- Result pending with out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 throughout, outputs stable. Raise out_ready → result drains; next vector 10, 20 (last) gives 30, count 2.
- Beats 100, 50, then flush=1 with in_valid=1, in_data=7 → beat dropped. Then 5 (last) → out_data=5, out_count=1.
- Continuous single-beat vectors 1, 2, 3 with out_ready=1 → out_valid held high 3 consecutive cycles with out_data 1, 2, 3. Assert rst mid-stream → out_valid=0 immediately, next vector starts from 0.
